// File: rtl/bit_serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_t   : controller state encoding (IDLE/RUN/DONE)
//   DEF_WIDTH : default operand/sum width
package serial_add_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bit_serial_adder_ctrl_if.sv
// Handshake/data bundle between operand producer, result consumer and the
// bit-serial adder controller.
//   in_valid/in_ready/a/b    : operand side
//   out_valid/out_ready/sum/cout : result side
//   busy                     : controller is in RUN
//   op_sub                   : subtract select (only with ADD_SUB_EN defined)
// Modports: master = producer/consumer side, slave = controller side.
interface bit_serial_adder_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef ADD_SUB_EN
    logic             op_sub;

    modport master (
        output in_valid, a, b, op_sub, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
    modport slave (
        input  in_valid, a, b, op_sub, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`else
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`endif
endinterface

// File: rtl/bit_serial_adder_ctrl_fa_cell.sv
// One-bit full adder built from two half adders and an OR for the carry.
//   half_adder : x, y -> s (sum), c (carry)
//   fa_cell    : x, y, cin -> s (sum), co (carry out)
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module fa_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic co
);
    logic s1, c1, c2;

    half_adder u_ha0 (.x(x),  .y(y),   .s(s1), .c(c1));
    half_adder u_ha1 (.x(s1), .y(cin), .s(s),  .c(c2));

    assign co = c1 | c2;
endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial adder controller: feeds one full-adder cell one bit per clock,
// LSB first, over a WIDTH-bit operand pair (WIDTH 2..32).
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : bit_serial_adder_ctrl_if.slave (operand/result handshakes, busy)
// Optional macro ADD_SUB_EN: adds bus.op_sub; when set at acceptance the
// block computes a-b mod 2^WIDTH and cout=1 means no borrow.
module bit_serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    bit_serial_adder_ctrl_if.slave bus
);
    localparam int unsigned      CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             in_ready_q, out_valid_q, busy_q, cout_q;
    logic [WIDTH-1:0] sum_q;

    logic             fa_s, fa_co;
    logic [WIDTH-1:0] sum_nxt;
    logic             sub_sel;

`ifdef ADD_SUB_EN
    assign sub_sel = bus.op_sub;
`else
    assign sub_sel = 1'b0;
`endif

    fa_cell u_fa (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .cin(carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // Cell sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
    assign sum_nxt = {fa_s, sum_sr[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            a_sr        <= '0;
            b_sr        <= '0;
            sum_sr      <= '0;
            carry       <= 1'b0;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        // Subtract = a + ~b + 1: invert b and seed the carry.
                        a_sr       <= bus.a;
                        b_sr       <= bus.b ^ {WIDTH{sub_sel}};
                        carry      <= sub_sel;
                        sum_sr     <= '0;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_nxt;
                    carry  <= fa_co;
                    if (cnt == LAST) begin
                        // Counter stays at WIDTH-1 rather than wrapping.
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        sum_q       <= sum_nxt;
                        cout_q      <= fa_co;
                        state       <= ST_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Scoreboard bench for bit_serial_adder_ctrl at WIDTH=4.
// Expected {cout,sum} values are queued at operand acceptance; a monitor pops
// and compares on every result handshake.
module tb_bit_serial_adder_ctrl;

    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bit_serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    bit_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int         vectors = 0;
    int         errs    = 0;
    logic [W:0] sb[$];
    time        last_accept = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result monitor: compare on each handshake that will complete at the next edge.
    initial begin
        logic [W:0] exp;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    vectors++;
                    errs++;
                    $display("FAIL result: unexpected {cout,sum}=%0h, none expected", {bus.cout, bus.sum});
                end else begin
                    exp = sb.pop_front();
                    check("result", 32'({bus.cout, bus.sum}), 32'(exp));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present operands until accepted; afterwards scramble a/b to show they are not re-sampled.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic [W:0] exp);
        int n;
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
`ifdef ADD_SUB_EN
        bus.op_sub = sub;
`else
        if (sub) $display("note: subtract requested without ADD_SUB_EN");
`endif
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 200);
        check("accept", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        last_accept = $time;
        sb.push_back(exp);
        #1;
        bus.in_valid = 1'b0;
        bus.a = ~a;
        bus.b = ~b;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  edges;
        time prev;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
`ifdef ADD_SUB_EN
        bus.op_sub = 1'b0;
`endif
        #2;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_sum",       32'(bus.sum),       32'd0);
        check("rst_cout",      32'(bus.cout),      32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 3+4: RUN for WIDTH edges after acceptance, then one DONE edge.
        do_op(4'h3, 4'h4, 1'b0, 5'h07);
        for (int k = 1; k <= int'(W); k++) begin
            @(posedge clk);
            #1;
            check("t1_in_ready",  32'(bus.in_ready),  32'd0);
            check("t1_out_valid", 32'(bus.out_valid), 32'(k == int'(W)));
            check("t1_busy",      32'(bus.busy),      32'(k < int'(W)));
        end
        @(posedge clk);
        #1;
        check("t1_in_ready_back", 32'(bus.in_ready),  32'd1);
        check("t1_out_valid_off", 32'(bus.out_valid), 32'd0);

        // Overflow cases.
        do_op(4'hF, 4'h1, 1'b0, 5'h10);
        do_op(4'hF, 4'hF, 1'b0, 5'h1E);
        drain();

        // Backpressure: result held, new operands ignored.
        bus.out_ready = 1'b0;
        do_op(4'h9, 4'h8, 1'b0, 5'h11);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!bus.out_valid && edges < 20);
        check("t3_latency", 32'(edges), 32'(W));
        for (int k = 0; k < 10; k++) begin
            if (k == 2) begin
                bus.in_valid = 1'b1;
                bus.a = 4'h2;
                bus.b = 4'h2;
            end
            if (k == 6) bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
            check("t3_sum",       32'(bus.sum),       32'h1);
            check("t3_cout",      32'(bus.cout),      32'd1);
            check("t3_in_ready",  32'(bus.in_ready),  32'd0);
            check("t3_out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t3_in_ready_back", 32'(bus.in_ready),  32'd1);
        check("t3_out_valid_off", 32'(bus.out_valid), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        check("t3_no_ghost_valid", 32'(bus.out_valid), 32'd0);
        check("t3_no_ghost_busy",  32'(bus.busy),      32'd0);

        // Reset during RUN cycle 2: outputs clear without a clock edge.
        do_op(4'h7, 4'h7, 1'b0, 5'h0E);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("t4_out_valid", 32'(bus.out_valid), 32'd0);
        check("t4_in_ready",  32'(bus.in_ready),  32'd1);
        check("t4_busy",      32'(bus.busy),      32'd0);
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        do_op(4'h5, 4'h6, 1'b0, 5'h0B);
        drain();

        // Exhaustive sweep, back to back: one acceptance every WIDTH+2 cycles.
        prev = 0;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            logic [W-1:0] ai, bi;
            v  = 8'(i);
            ai = v[7:4];
            bi = v[3:0];
            do_op(ai, bi, 1'b0, {1'b0, ai} + {1'b0, bi});
            if (i > 0) check("t5_interval", 32'(last_accept - prev), 32'd60);
            prev = last_accept;
        end
        drain();

`ifdef ADD_SUB_EN
        do_op(4'h5, 4'h3, 1'b1, 5'h12);
        do_op(4'h3, 4'h5, 1'b1, 5'h0E);
        drain();
`endif

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/bit_serial_adder_ctrl.md
Name: bit_serial_adder_ctrl

Overview:
- Sequencer that time-multiplexes a single 1-bit adder cell over a WIDTH-bit operand pair, one bit per clock, LSB first.
- Gives the team a multi-bit adder at minimum area, with valid/ready handshakes on both sides.
- Sits between an operand producer and a result consumer.
- The adder cell is the existing half-adder pair arranged as a full adder.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH)+1, bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  registered sum
- cout  output  1  registered carry-out of MSB
- busy  output  1  high in RUN state
- op_sub  input  1  subtract select; present only when ADD_SUB_EN is defined

Behaviour:
- Reset (asynchronous, active-high): all outputs are 0 except in_ready=1. The state machine goes to IDLE. Shift registers, carry and counter clear.
- States:
  - IDLE: in_ready=1. When in_valid=1 at a clock edge:
    - latch a and b into shift registers;
    - carry register set to 0 (1 when subtracting);
    - counter set to 0;
    - go to RUN.
  - RUN: in_ready=0, busy=1. Each cycle:
    - the adder cell takes a_sr[0], b_sr[0] and the carry register;
    - the cell's sum bit shifts into the MSB of sum_sr, and a_sr/b_sr shift right;
    - the carry register updates and the counter increments.
    - After the cycle where counter==WIDTH-1, go to DONE.
  - DONE: out_valid=1. sum=sum_sr and cout=carry register, both held stable while out_valid=1. On out_valid&&out_ready, go to IDLE and out_valid falls on the next cycle.
- Latency: handshake edge, then exactly WIDTH RUN cycles, then out_valid rises. This gives WIDTH+1 cycles from acceptance to first result visibility.
- Throughput: one operation per WIDTH+2 cycles when out_ready is held high.
- No back-to-back acceptance: in_ready rises only after the result handshake completes.
- Inputs a and b are sampled only at the accept edge; later changes are ignored.
- in_valid in RUN/DONE is ignored and is not queued.
- out_ready in IDLE/RUN has no effect.
- Overflow: cout=1 with sum wrapped modulo 2^WIDTH. No saturation.
- Reset mid-RUN or mid-DONE: the operation is abandoned and no result is emitted. Outputs return to reset values immediately, without waiting for a clock edge.
- Counter never exceeds WIDTH-1 in RUN. Illegal state encodings return to IDLE.

Optional Feature:
- Macro: ADD_SUB_EN.
- When defined:
  - port op_sub exists and is sampled at acceptance;
  - when op_sub=1, b is inverted into b_sr and the initial carry is 1, so sum=a-b mod 2^WIDTH;
  - cout=1 means no borrow (a>=b unsigned).
- When undefined: op_sub port absent, add only, initial carry always 0.

Decomposition:
- Shared package serial_add_pkg:
  - state encoding ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - default WIDTH constant.
- One sub-module: fa_cell. It is a combinational full adder built from two half adder instances plus an OR for carry, with ports x, y, cin, s, co.
- The controller holds the FSM, shift registers, counter and carry flop.

Test Plan:
- WIDTH=4, a=4'h3, b=4'h4, in_valid pulse, out_ready=1 → in_ready low for 5 cycles; out_valid high on cycle 5; sum=4'h7, cout=0.
- WIDTH=4, a=4'hF, b=4'h1 → sum=4'h0, cout=1. Then a=4'hF, b=4'hF → sum=4'hE, cout=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid → sum/cout stable, in_ready=0, and a new in_valid with different operands is ignored. Raising out_ready completes the handshake and in_ready returns next cycle.
- Reset asserted during RUN on cycle 2 → out_valid=0, in_ready=1, busy=0 with no clock edge. A fresh operation a=4'h5, b=4'h6 afterwards yields sum=4'hB, cout=0.
- Exhaustive WIDTH=4 sweep of all 256 operand pairs back to back with out_ready=1 → every {cout,sum} equals a+b, one result per 6 cycles.
- ADD_SUB_EN defined:
  - op_sub=1, a=4'h5, b=4'h3 → sum=4'h2, cout=1;
  - op_sub=1, a=4'h3, b=4'h5 → sum=4'hE, cout=0.
